lsu_axi_master: RTL and testbench

LSU_AXI_MASTER -- requirements
Module: ysyx_23060077_riscv_lsu_axi_master

---
 rtl/lsu_axi_master.sv | 220 ++++++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: single-outstanding AXI4-Lite style master behind the CPU load/store unit.
//
// A CPU request (req_*) is registered on acceptance. Reads are issued as an AR beat followed by
// one R beat. Writes are issued as independent AW and W beats followed by one B beat. Every
// transaction ends with a single-cycle rsp_valid_o pulse carrying read data and an error flag.
// The master returns to idle in the same cycle it raises rsp_valid_o, so a new request can be
// accepted during the response cycle.
//
// Optional feature: defining AXI_MASTER_TIMEOUT_EN adds a watchdog. A transaction that has not
// completed TIMEOUT_CYCLES cycles after its acceptance cycle is abandoned. It then reports
// rsp_err_o=1 and rsp_rdata_o=0. Without the macro, TIMEOUT_CYCLES is unused and the master
// waits indefinitely. With the macro, TIMEOUT_CYCLES must be 2 or more.
//
// Ports
//   aclk, areset_n            clock; synchronous active-low reset
//   req_valid_i/req_ready_o   CPU request handshake (ready only while idle)
//   req_wen_i                 1 = write, 0 = read
//   req_addr_i, req_wdata_i, req_wstrb_i   request payload
//   rsp_valid_o               one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o    read data / error (held until the next completion)
//   axi_aw_*, axi_w_*, axi_b_*             write address / data / response channels
//   axi_ar_*, axi_r_*                      read address / data channels
// AXI protection outputs (axi_*_port_o) are tied to 3'b000.

module lsu_axi_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        aclk,
   input  logic        areset_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wen_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_wstrb_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        axi_aw_valid_o,
   input  logic        axi_aw_ready_i,
   output logic [31:0] axi_aw_addr_o,
   output logic [2:0]  axi_aw_port_o,
   output logic        axi_w_valid_o,
   input  logic        axi_w_ready_i,
   output logic [31:0] axi_w_data_o,
   output logic [3:0]  axi_w_strb_o,
   input  logic        axi_b_valid_i,
   output logic        axi_b_ready_o,
   input  logic [1:0]  axi_b_resp_i,
   output logic        axi_ar_valid_o,
   input  logic        axi_ar_ready_i,
   output logic [31:0] axi_ar_addr_o,
   output logic [2:0]  axi_ar_port_o,
   input  logic        axi_r_valid_i,
   output logic        axi_r_ready_o,
   input  logic [1:0]  axi_r_resp_i,
   input  logic [31:0] axi_r_data_i
);

   typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWreq, StWresp} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        accept;
   logic        timeout;

   // The request direction is not stored separately; it is carried by the state (RADDR vs WREQ).
   assign req_ready_o = (state_q == StIdle);
   assign accept      = req_valid_i & req_ready_o;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   // cnt_q is the number of cycles elapsed since the acceptance cycle. It starts at 1 in the
   // first busy cycle. Aborting when it reaches TIMEOUT_CYCLES-1 puts the error response exactly
   // TIMEOUT_CYCLES cycles after acceptance, the same way normal completion latency is counted.
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = CntW'(1);
      end else if (state_q != StIdle) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign timeout = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               addr_d    = req_addr_i;
               wdata_d   = req_wdata_i;
               wstrb_d   = req_wstrb_i;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = req_wen_i ? StWreq : StRaddr;
            end
         end
         // axi_ar_valid_o is high throughout RADDR, so ready alone completes the handshake.
         StRaddr: begin
            if (axi_ar_ready_i) begin
               state_d = StRdata;
            end
         end
         StRdata: begin
            if (axi_r_valid_i) begin
               rdata_d     = axi_r_data_i;
               err_d       = (axi_r_resp_i != 2'b00);
               rsp_valid_d = 1'b1;
               state_d     = StIdle;
            end
         end
         // Each of AW/W is still valid only while its done flag is clear, so OR-ing ready in
         // records that channel's handshake.
         StWreq: begin
            aw_done_d = aw_done_q | axi_aw_ready_i;
            w_done_d  = w_done_q | axi_w_ready_i;
            if (aw_done_d && w_done_d) begin
               // b_ready is already high here; honour a B that arrives once both beats are out.
               if (axi_b_valid_i) begin
                  err_d       = (axi_b_resp_i != 2'b00);
                  rsp_valid_d = 1'b1;
                  state_d     = StIdle;
               end else begin
                  state_d = StWresp;
               end
            end
         end
         StWresp: begin
            if (axi_b_valid_i) begin
               err_d       = (axi_b_resp_i != 2'b00);
               rsp_valid_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (timeout) begin
         state_d     = StIdle;
         rsp_valid_d = 1'b1;
         err_d       = 1'b1;
         rdata_d     = '0;
      end
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
      end
   end

   // Every valid/ready output is a function of registered state only.
   assign axi_ar_valid_o = (state_q == StRaddr);
   assign axi_r_ready_o  = (state_q == StRaddr) || (state_q == StRdata);
   assign axi_aw_valid_o = (state_q == StWreq) && !aw_done_q;
   assign axi_w_valid_o  = (state_q == StWreq) && !w_done_q;
   assign axi_b_ready_o  = (state_q == StWreq) || (state_q == StWresp);

   assign axi_ar_addr_o = addr_q;
   assign axi_aw_addr_o = addr_q;
   assign axi_w_data_o  = wdata_q;
   assign axi_w_strb_o  = wstrb_q;
   assign axi_ar_port_o = 3'b000;
   assign axi_aw_port_o = 3'b000;

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Testbench for lsu_axi_master: directed and randomized read/write transactions against a
// reactive AXI responder. The responder stalls each channel for a chosen number of cycles.
// Expected response timing and contents come from a transaction-level model:
//   read latency  = 3 + AR stall + R stall
//   write latency = 3 + max(AW stall, W stall) + B stall
//   rdata         = R data on reads, unchanged on writes, 0 after reset or timeout
//   err           = (resp != 0)

module tb_lsu_axi_master;

   logic        aclk;
   logic        areset_n;
   logic        req_valid_i, req_ready_o, req_wen_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [3:0]  req_wstrb_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        axi_aw_valid_o, axi_aw_ready_i;
   logic [31:0] axi_aw_addr_o;
   logic [2:0]  axi_aw_port_o;
   logic        axi_w_valid_o, axi_w_ready_i;
   logic [31:0] axi_w_data_o;
   logic [3:0]  axi_w_strb_o;
   logic        axi_b_valid_i, axi_b_ready_o;
   logic [1:0]  axi_b_resp_i;
   logic        axi_ar_valid_o, axi_ar_ready_i;
   logic [31:0] axi_ar_addr_o;
   logic [2:0]  axi_ar_port_o;
   logic        axi_r_valid_i, axi_r_ready_o;
   logic [1:0]  axi_r_resp_i;
   logic [31:0] axi_r_data_i;

   int          n_checks = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   logic [31:0] last_rdata;

   lsu_axi_master #(.TIMEOUT_CYCLES(8)) dut (
      .aclk           (aclk),
      .areset_n       (areset_n),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_wen_i      (req_wen_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .req_wstrb_i    (req_wstrb_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .axi_aw_valid_o (axi_aw_valid_o),
      .axi_aw_ready_i (axi_aw_ready_i),
      .axi_aw_addr_o  (axi_aw_addr_o),
      .axi_aw_port_o  (axi_aw_port_o),
      .axi_w_valid_o  (axi_w_valid_o),
      .axi_w_ready_i  (axi_w_ready_i),
      .axi_w_data_o   (axi_w_data_o),
      .axi_w_strb_o   (axi_w_strb_o),
      .axi_b_valid_i  (axi_b_valid_i),
      .axi_b_ready_o  (axi_b_ready_o),
      .axi_b_resp_i   (axi_b_resp_i),
      .axi_ar_valid_o (axi_ar_valid_o),
      .axi_ar_ready_i (axi_ar_ready_i),
      .axi_ar_addr_o  (axi_ar_addr_o),
      .axi_ar_port_o  (axi_ar_port_o),
      .axi_r_valid_i  (axi_r_valid_i),
      .axi_r_ready_o  (axi_r_ready_o),
      .axi_r_resp_i   (axi_r_resp_i),
      .axi_r_data_i   (axi_r_data_i)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic axi_quiet();
      axi_aw_ready_i = 1'b0;
      axi_w_ready_i  = 1'b0;
      axi_b_valid_i  = 1'b0;
      axi_b_resp_i   = 2'b00;
      axi_ar_ready_i = 1'b0;
      axi_r_valid_i  = 1'b0;
      axi_r_resp_i   = 2'b00;
      axi_r_data_i   = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge aclk);
         #1;
         chk("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
         chk("idle_req_ready", 32'(req_ready_o), 32'd1);
      end
   endtask

   // Entered at #1 in a cycle where the DUT is idle; this becomes the acceptance cycle.
   // Returns in the response cycle, so a following call is issued back-to-back.
   // Read:  wa = AR stall, wb = R stall.  Write: wa = AW stall, wb = W stall, wc = B stall.
   task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp,
                          input int wa, input int wb, input int wc);
      int   exp_lat, ca, cb, cc, a_beats, b_beats;
      logic a_seen, b_seen;
      exp_lat = wen ? 3 + ((wa > wb) ? wa : wb) + wc : 3 + wa + wb;
      ca = 0; cb = 0; cc = 0; a_beats = 0; b_beats = 0; a_seen = 1'b0; b_seen = 1'b0;
      chk("req_ready_accept", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1;
      req_wen_i   = wen;
      req_addr_i  = addr;
      req_wdata_i = wen ? data : $urandom;
      req_wstrb_i = strb;
      for (int cyc = 1; cyc <= exp_lat; cyc++) begin
         @(posedge aclk);
         #1;
         if (cyc == 1) begin
            // Scramble the request bus to show the payload was registered.
            req_valid_i = 1'b0;
            req_addr_i  = $urandom;
            req_wdata_i = $urandom;
            req_wstrb_i = 4'($urandom);
         end
         chk("rsp_valid", 32'(rsp_valid_o), 32'(cyc == exp_lat));
         if (cyc == exp_lat) begin
            if (!wen) last_rdata = data;
            chk("rsp_rdata", rsp_rdata_o, last_rdata);
            chk("rsp_err", 32'(rsp_err_o), 32'(resp != 2'b00));
            chk("req_ready_rsp", 32'(req_ready_o), 32'd1);
            if (wen) begin
               chk("aw_beats", 32'(a_beats), 32'd1);
               chk("w_beats", 32'(b_beats), 32'd1);
            end else begin
               chk("ar_beats", 32'(a_beats), 32'd1);
            end
            axi_quiet();
         end else if (!wen) begin
            chk("req_ready_busy", 32'(req_ready_o), 32'd0);
            chk("ar_valid", 32'(axi_ar_valid_o), 32'(!a_seen));
            if (!a_seen) chk("ar_addr", axi_ar_addr_o, addr);
            chk("ar_port", 32'(axi_ar_port_o), 32'd0);
            chk("r_ready", 32'(axi_r_ready_o), 32'd1);
            axi_ar_ready_i = !a_seen && (ca >= wa);
            if (a_seen) begin
               axi_r_valid_i = (cb >= wb);
               axi_r_data_i  = axi_r_valid_i ? data : $urandom;
               axi_r_resp_i  = axi_r_valid_i ? resp : 2'($urandom);
               cb++;
            end else begin
               // Stray R beats before the AR handshake must be ignored.
               axi_r_valid_i = 1'($urandom);
               axi_r_data_i  = $urandom;
               axi_r_resp_i  = 2'($urandom);
               ca++;
            end
            axi_b_valid_i = 1'($urandom);
            axi_b_resp_i  = 2'($urandom);
            if (axi_ar_valid_o && axi_ar_ready_i) begin
               a_seen = 1'b1;
               a_beats++;
            end
         end else begin
            chk("req_ready_busy", 32'(req_ready_o), 32'd0);
            chk("aw_valid", 32'(axi_aw_valid_o), 32'(!a_seen));
            chk("w_valid", 32'(axi_w_valid_o), 32'(!b_seen));
            if (!a_seen) chk("aw_addr", axi_aw_addr_o, addr);
            if (!b_seen) begin
               chk("w_data", axi_w_data_o, data);
               chk("w_strb", 32'(axi_w_strb_o), 32'(strb));
            end
            chk("aw_port", 32'(axi_aw_port_o), 32'd0);
            chk("b_ready", 32'(axi_b_ready_o), 32'd1);
            axi_aw_ready_i = !a_seen && (ca >= wa);
            axi_w_ready_i  = !b_seen && (cb >= wb);
            axi_b_valid_i  = a_seen && b_seen && (cc >= wc);
            axi_b_resp_i   = axi_b_valid_i ? resp : 2'($urandom);
            if (a_seen && b_seen) cc++;
            if (!a_seen) ca++;
            if (!b_seen) cb++;
            axi_r_valid_i = 1'($urandom);
            axi_r_data_i  = $urandom;
            axi_r_resp_i  = 2'($urandom);
            if (axi_aw_valid_o && axi_aw_ready_i) begin
               a_seen = 1'b1;
               a_beats++;
            end
            if (axi_w_valid_o && axi_w_ready_i) begin
               b_seen = 1'b1;
               b_beats++;
            end
         end
      end
   endtask

   initial begin
      int          pulses;
      logic        r_wen;
      logic [1:0]  r_resp;
      areset_n    = 1'b0;
      req_valid_i = 1'b0;
      req_wen_i   = 1'b0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      req_wstrb_i = '0;
      axi_quiet();
      last_rdata  = '0;

      repeat (3) @(posedge aclk);
      #1;
      chk("rst_ar_valid", 32'(axi_ar_valid_o), 32'd0);
      chk("rst_aw_valid", 32'(axi_aw_valid_o), 32'd0);
      chk("rst_w_valid", 32'(axi_w_valid_o), 32'd0);
      chk("rst_r_ready", 32'(axi_r_ready_o), 32'd0);
      chk("rst_b_ready", 32'(axi_b_ready_o), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
      chk("rst_ar_addr", axi_ar_addr_o, 32'd0);
      chk("rst_w_data", axi_w_data_o, 32'd0);
      areset_n = 1'b1;
      @(posedge aclk);
      #1;
      chk("rst_req_ready", 32'(req_ready_o), 32'd1);

      // Read, AR immediate, R two cycles later.
      run_txn(1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 2, 0);
      idle(2);
      // Write, W ready three cycles before AW ready.
      run_txn(1'b1, 32'h8000_0020, 32'h1234_5678, 4'b0011, 2'b00, 3, 0, 0);
      idle(1);
      // SLVERR read.
      run_txn(1'b0, 32'h8000_0030, 32'hCAFE_F00D, 4'hF, 2'b10, 1, 0, 0);
      idle(1);
      // Back-to-back read then write with zero-wait responder.
      run_txn(1'b0, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 2'b00, 0, 0, 0);
      run_txn(1'b1, 32'h8000_0044, 32'hA5A5_5A5A, 4'b1100, 2'b00, 0, 0, 0);
      idle(1);

      for (int i = 0; i < 40; i++) begin
         r_wen  = 1'($urandom);
         r_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run_txn(r_wen, $urandom, $urandom, 4'($urandom), r_resp, $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      idle(1);

      // AR never ready.
      chk("stall_req_ready", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1;
      req_wen_i   = 1'b0;
      req_addr_i  = 32'h8000_0050;
`ifdef AXI_MASTER_TIMEOUT_EN
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(posedge aclk);
         #1;
         req_valid_i = 1'b0;
         chk("to_rsp_valid", 32'(rsp_valid_o), 32'(cyc == 8));
         chk("to_ar_valid", 32'(axi_ar_valid_o), 32'(cyc < 8));
         if (cyc == 8) begin
            chk("to_err", 32'(rsp_err_o), 32'd1);
            chk("to_rdata", rsp_rdata_o, 32'd0);
            chk("to_req_ready", 32'(req_ready_o), 32'd1);
         end
      end
      last_rdata = '0;
`else
      pulses = 0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(posedge aclk);
         #1;
         req_valid_i = 1'b0;
         if (rsp_valid_o) pulses++;
      end
      chk("stall_no_rsp", 32'(pulses), 32'd0);
      chk("stall_ar_valid", 32'(axi_ar_valid_o), 32'd1);
      chk("stall_ar_addr", axi_ar_addr_o, 32'h8000_0050);
      areset_n = 1'b0;
      @(posedge aclk);
      #1;
      chk("stall_rst_ar_valid", 32'(axi_ar_valid_o), 32'd0);
      areset_n = 1'b1;
      last_rdata = '0;
`endif
      idle(1);

      // Reset while waiting in RDATA aborts silently and clears the response registers.
      run_txn(1'b0, 32'h8000_0060, 32'h7777_1234, 4'hF, 2'b00, 0, 0, 0);
      idle(1);
      req_valid_i = 1'b1;
      req_wen_i   = 1'b0;
      req_addr_i  = 32'h8000_0070;
      @(posedge aclk);
      #1;
      req_valid_i    = 1'b0;
      axi_ar_ready_i = 1'b1;
      chk("mid_ar_valid", 32'(axi_ar_valid_o), 32'd1);
      @(posedge aclk);
      #1;
      axi_ar_ready_i = 1'b0;
      chk("mid_r_ready", 32'(axi_r_ready_o), 32'd1);
      areset_n = 1'b0;
      @(posedge aclk);
      #1;
      chk("mid_rst_r_ready", 32'(axi_r_ready_o), 32'd0);
      chk("mid_rst_ar_valid", 32'(axi_ar_valid_o), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      areset_n      = 1'b1;
      axi_r_valid_i = 1'b1;
      axi_r_data_i  = 32'h5555_AAAA;
      @(posedge aclk);
      #1;
      axi_r_valid_i = 1'b0;
      last_rdata    = '0;
      chk("mid_post_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("mid_post_req_ready", 32'(req_ready_o), 32'd1);
      chk("mid_post_rdata", rsp_rdata_o, last_rdata);
      idle(1);
      run_txn(1'b0, 32'h8000_0080, 32'h0101_0202, 4'hF, 2'b00, 0, 1, 0);
      idle(1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
